// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (processor = 0, UART = 1) with hold-limited fairness and owner lock.
// Optional access/stall statistics counters are built only when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wrEn,
    output logic [DATA_WIDTH-1:0] mem_dataIn,
    input  logic [DATA_WIDTH-1:0] mem_dataOut,
    output logic [15:0]           acc_cnt0,
    output logic [15:0]           acc_cnt1,
    output logic [15:0]           wait_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     stateReg, stateNext;
    logic       rrReg, rrNext;
    logic [7:0] holdReg, holdNext;
    logic [1:0] reqV, weV, accV, rvalidV;

    assign reqV  = {req1, req0};
    assign weV   = {we1, we0};
    assign gnt0  = (stateReg == OWN0);
    assign gnt1  = (stateReg == OWN1);
    assign accV  = {gnt1 & req1, gnt0 & req0};
    assign rdata = mem_dataOut;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateReg <= IDLE;
            rrReg    <= 1'b0;
            holdReg  <= 8'd0;
        end else begin
            stateReg <= stateNext;
            rrReg    <= rrNext;
            holdReg  <= holdNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (req0 && req1)
                    stateNext = rrReg ? OWN1 : OWN0;
                else if (req0)
                    stateNext = OWN0;
                else if (req1)
                    stateNext = OWN1;
            end
            OWN0: begin
                if (!req0)
                    stateNext = req1 ? OWN1 : IDLE;
                else if (req1 && !lock0 && holdReg == HOLD_LAST)
                    stateNext = OWN1;
            end
            OWN1: begin
                if (!req1)
                    stateNext = req0 ? OWN0 : IDLE;
                else if (req0 && !lock1 && holdReg == HOLD_LAST)
                    stateNext = OWN0;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Leaving an owner state hands the round-robin preference to the other side.
    always_comb begin
        rrNext     = rrReg;
        holdNext   = holdReg;
        mem_wrEn   = 1'b0;
        mem_addr   = '0;
        mem_dataIn = '0;
        if (stateNext != stateReg) begin
            holdNext = 8'd0;
            if (stateReg == OWN0)
                rrNext = 1'b1;
            else if (stateReg == OWN1)
                rrNext = 1'b0;
        end else if (|accV) begin
            holdNext = holdReg + 8'd1;
        end
        if (accV[0]) begin
            mem_wrEn   = we0;
            mem_addr   = addr0;
            mem_dataIn = wdata0;
        end else if (accV[1]) begin
            mem_wrEn   = we1;
            mem_addr   = addr1;
            mem_dataIn = wdata1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gRvalid
            logic rvalidReg;
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN)
                    rvalidReg <= 1'b0;
                else
                    rvalidReg <= accV[gi] & ~weV[gi];
            end
            assign rvalidV[gi] = rvalidReg;
        end
    endgenerate

    assign rvalid0 = rvalidV[0];
    assign rvalid1 = rvalidV[1];

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] accCntV [2];
    logic [15:0] waitCntReg;

    generate
        for (gi = 0; gi < 2; gi++) begin : gAccCnt
            logic [15:0] cntReg;
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN)
                    cntReg <= 16'd0;
                else if (accV[gi] && cntReg != 16'hFFFF)
                    cntReg <= cntReg + 16'd1;
            end
            assign accCntV[gi] = cntReg;
        end
    endgenerate

    // One stall per cycle no matter how many requesters are waiting.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            waitCntReg <= 16'd0;
        else if ((|(reqV & ~accV)) && waitCntReg != 16'hFFFF)
            waitCntReg <= waitCntReg + 16'd1;
    end

    assign acc_cnt0 = accCntV[0];
    assign acc_cnt1 = accCntV[1];
    assign wait_cnt = waitCntReg;
`else
    assign acc_cnt0 = 16'd0;
    assign acc_cnt1 = 16'd0;
    assign wait_cnt = 16'd0;
`endif

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, the data memory word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, the data memory address width in bits.
REQ-003 SHALL have parameter MAX_HOLD, default 16, the number of consecutive unlocked accesses before ownership must be offered to the other requester (legal range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rstN, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports req0/req1, input, 1 bit each: access request; requester 0 is the processor and requester 1 is the UART memory interface.
REQ-007 SHALL have ports we0/we1, input, 1 bit each: 1 = write, 0 = read.
REQ-008 SHALL have ports lock0/lock1, input, 1 bit each: keep ownership regardless of MAX_HOLD.
REQ-009 SHALL have ports addr0/addr1, input, ADDR_WIDTH each: access address.
REQ-010 SHALL have ports wdata0/wdata1, input, DATA_WIDTH each: write data.
REQ-011 SHALL have ports gnt0/gnt1, output, 1 bit each: registered ownership flag.
REQ-012 SHALL have ports rvalid0/rvalid1, output, 1 bit each: read data valid.
REQ-013 SHALL have port rdata, output, DATA_WIDTH: read data, equal to mem_dataOut.
REQ-014 SHALL have port mem_addr, output, ADDR_WIDTH: RAM address.
REQ-015 SHALL have port mem_wrEn, output, 1 bit: RAM write enable.
REQ-016 SHALL have port mem_dataIn, output, DATA_WIDTH: RAM write data.
REQ-017 SHALL have port mem_dataOut, input, DATA_WIDTH: RAM registered read data (1-cycle latency).
REQ-018 SHALL have ports acc_cnt0/acc_cnt1, output, 16 bits each: accepted-access counters.
REQ-019 SHALL have port wait_cnt, output, 16 bits: stall-cycle counter.

Function
REQ-020 SHALL implement a state machine with states IDLE, OWN0 and OWN1; gnt0 = (state==OWN0) and gnt1 = (state==OWN1), both registered.
REQ-021 SHALL count an access as accepted in any cycle where gnt_i && req_i; mem_addr/mem_dataIn = addr_i/wdata_i and mem_wrEn = we_i in that cycle, combinationally.
REQ-022 SHALL drive mem_wrEn=0, mem_addr=0 and mem_dataIn=0 in cycles with no accepted access.
REQ-023 SHALL assert rvalid_i for exactly one cycle, the cycle after an accepted read by requester i; rvalid SHALL NOT be asserted after a write.
REQ-024 SHALL transition from IDLE: a single req_i -> OWN_i; both requests -> OWN of the requester indicated by the round-robin pointer rr; none -> remain IDLE.
REQ-025 SHALL transition from OWN_i when req_i=0: to OWN_other if req_other=1, else to IDLE.
REQ-026 SHALL transition from OWN_i to OWN_other when req_i=1, req_other=1, lock_i=0 and hold_cnt == MAX_HOLD-1 with an access accepted that cycle.
REQ-027 SHALL stay in OWN_i in all other cases.
REQ-028 SHALL make a grant change visible on the next clock edge and SHALL NOT produce a cycle with both gnt0 and gnt1 high.
REQ-029 SHALL use hold_cnt (8 bits) to count accepted accesses in the current ownership, clearing it on every state change.
REQ-030 SHALL set rr to the other requester whenever leaving OWN_i, so that it favours the last loser.
REQ-031 SHALL keep lock_i set indefinitely while req_i is held, and SHALL ignore lock_i when not owner.
REQ-032 SHALL complete an in-flight read's rvalid on the following cycle even if ownership changes on that edge.

Reset
REQ-033 SHALL, while rstN=0 (asynchronous), set state=IDLE, rr=0, hold_cnt=0, gnt0=gnt1=0, rvalid0=rvalid1=0, mem_wrEn=0 and all counters to 0.
REQ-034 SHALL discard any in-flight read on reset mid-access, with no rvalid after release; the first post-reset grant SHALL follow REQ-024.

Configuration
REQ-035 SHALL, when macro DMEM_ARB_STATS_EN is defined, increment acc_cnt_i on each accepted access of requester i and increment wait_cnt on each cycle where some req_i=1 and no access by i is accepted; all three counters SHALL saturate at 16'hFFFF.
REQ-036 SHALL, when DMEM_ARB_STATS_EN is undefined, tie acc_cnt0, acc_cnt1 and wait_cnt to 0 and instantiate no counter logic; all other behaviour SHALL be identical.

Verification
REQ-037 SHALL cover single requester: req1 with read at addr 5 -> gnt1 next cycle, mem_addr=5, rvalid1 one cycle later with rdata=RAM[5].
REQ-038 SHALL cover a simultaneous request after reset: both req from IDLE -> OWN0 (rr=0); on req0 drop -> OWN1 next cycle, no overlap.
REQ-039 SHALL cover fairness with MAX_HOLD=4: both continuously requesting, locks low -> ownership alternates every 4 accepted accesses.
REQ-040 SHALL cover lock: lock0=1, req0 held 20 cycles with req1=1 -> gnt0 stays 20 cycles; with stats enabled, wait_cnt=20.
REQ-041 SHALL cover reset mid-read: rstN low in the cycle after an accepted read -> no rvalid, state IDLE, all outputs 0.
REQ-042 SHALL cover the write path: req0 we0=1 addr 7 wdata 24'h00ABC -> mem_wrEn=1 for one accepted cycle, no rvalid0; acc_cnt0=1 with DMEM_ARB_STATS_EN and 0 without.
